// File: rtl/sram_pkg.sv
// Shared state encoding, counter width and parameter legality check for sram_ctrl_gen.
// Latency: none (declarations only).
// Backpressure: none (declarations only). Optional TURN state exists only with SRAM_CTRL_TURN_EN.
package sram_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_WRH  = 3'd3
`ifdef SRAM_CTRL_TURN_EN
        ,
        ST_TURN = 3'd4
`endif
    } sram_state_t;

    // Legal when the data bus is whole bytes and both wait counts fit the counter.
    function automatic bit sram_params_ok(input int data_w, input int rd_wait, input int wr_wait);
        return (data_w >= 8) && ((data_w % 8) == 0) &&
               (rd_wait >= 0) && (rd_wait <= (1 << WAIT_CNT_W) - 1) &&
               (wr_wait >= 0) && (wr_wait <= (1 << WAIT_CNT_W) - 1);
    endfunction

endpackage

// File: rtl/sram_dq_buf.sv
// Tristate driver for the SRAM data bus with a combinational view of the pins.
// Latency: zero, purely combinational.
// Backpressure: none; drives dq whenever oe is high.
module sram_dq_buf #(
    parameter int DATA_W = 16
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] dq
);

    assign dq  = oe ? dout : {DATA_W{1'bz}};
    assign din = dq;

endmodule

// File: rtl/sram_ctrl_gen.sv
// Valid/ready request port to one asynchronous SRAM chip, byte enables and programmable waits.
// Latency: read accept at edge T gives rsp_valid in cycle T+RD_WAIT+2; write occupies WR_WAIT+3 cycles.
// Backpressure: req_ready only in IDLE; one access at a time. SRAM_CTRL_TURN_EN adds a post-read gap.
module sram_ctrl_gen
    import sram_pkg::*;
#(
    parameter  int ADDR_W  = 18,
    parameter  int DATA_W  = 16,
    parameter  int RD_WAIT = 1,
    parameter  int WR_WAIT = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] rdata_ur,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [BE_W-1:0]   sram_be_n
);

    if (!sram_params_ok(DATA_W, RD_WAIT, WR_WAIT)) begin : g_param_err
        $error("sram_ctrl_gen: DATA_W must be a multiple of 8 and waits must be 0..15");
    end

    sram_state_t             state, state_nxt;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [DATA_W-1:0]       wdata_q, wdata_nxt;
    logic [BE_W-1:0]         be_q, be_nxt;
    logic                    ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe, dq_oe_nxt;
    logic [BE_W-1:0]         be_n_nxt;
    logic [DATA_W-1:0]       dq_in;
    logic                    rd_done;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rd_done   = (state == ST_RD) && (cnt == '0);
    assign rdata_ur  = dq_in;

    sram_dq_buf #(.DATA_W(DATA_W)) u_dq_buf (
        .oe   (dq_oe),
        .dout (wdata_q),
        .din  (dq_in),
        .dq   (sram_dq)
    );

    // Next state, wait counter and request latches; direction is carried by the state itself.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = sram_addr;
        wdata_nxt = wdata_q;
        be_nxt    = be_q;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    be_nxt    = req_be;
                    if (req_we) begin
                        state_nxt = ST_WR;
                        cnt_nxt   = WAIT_CNT_W'(WR_WAIT);
                    end else begin
                        state_nxt = ST_RD;
                        cnt_nxt   = WAIT_CNT_W'(RD_WAIT);
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
`ifdef SRAM_CTRL_TURN_EN
                    state_nxt = ST_TURN;
`else
                    state_nxt = ST_IDLE;
`endif
                end else begin
                    cnt_nxt = cnt - WAIT_CNT_W'(1);
                end
            end
            ST_WR: begin
                if (cnt == '0) begin
                    state_nxt = ST_WRH;
                end else begin
                    cnt_nxt = cnt - WAIT_CNT_W'(1);
                end
            end
            ST_WRH:  state_nxt = ST_IDLE;
`ifdef SRAM_CTRL_TURN_EN
            ST_TURN: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pin values for the state being entered, so the SRAM strobes come straight from flops.
    always_comb begin
        ce_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        be_n_nxt  = '1;
        dq_oe_nxt = 1'b0;
        case (state_nxt)
            ST_RD: begin
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                be_n_nxt = '0;
            end
            ST_WR: begin
                ce_n_nxt  = 1'b0;
                we_n_nxt  = 1'b0;
                be_n_nxt  = ~be_nxt;
                dq_oe_nxt = 1'b1;
            end
            ST_WRH: begin
                ce_n_nxt  = 1'b0;
                be_n_nxt  = ~be_nxt;
                dq_oe_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM state and wait counter; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered SRAM pins, request latches and read response capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sram_addr <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            dq_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            sram_addr <= addr_nxt;
            wdata_q   <= wdata_nxt;
            be_q      <= be_nxt;
            sram_ce_n <= ce_n_nxt;
            sram_oe_n <= oe_n_nxt;
            sram_we_n <= we_n_nxt;
            sram_be_n <= be_n_nxt;
            dq_oe     <= dq_oe_nxt;
            rsp_valid <= rd_done;
            if (rd_done) begin
                rsp_rdata <= dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl_gen.sv
// Bench for sram_ctrl_gen: async-SRAM chip model, reference memory and response scoreboard.
// Latency: checks read response timing against accept cycle + RD_WAIT + 1 edges.
// Backpressure: requests are held until accepted, with a bounded wait.
module tb_sram_ctrl_gen;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 1;
`ifdef SRAM_CTRL_TURN_EN
    localparam int B2B_PERIOD = RD_WAIT + 3;
`else
    localparam int B2B_PERIOD = RD_WAIT + 2;
`endif

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [DATA_W-1:0] rdata_ur;
    logic              busy;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_dq;
    logic              sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]        sram_be_n;

    sram_ctrl_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rdata_ur(rdata_ur), .busy(busy),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    // Asynchronous SRAM chip: drives dq while selected and output-enabled, stores enabled lanes while we_n low.
    logic [15:0] chip [0:(1<<ADDR_W)-1];
    logic        chip_init_done = 1'b0;
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? chip[sram_addr] : 16'bz;

    always @(posedge clk) begin
        if (!chip_init_done) begin
            for (int i = 0; i < (1 << ADDR_W); i++) chip[i] <= init_val(ADDR_W'(i));
            chip_init_done <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 2; b++)
                if (!sram_be_n[b]) chip[sram_addr][8*b +: 8] <= sram_dq[8*b +: 8];
        end
    end

    // Reference memory: what each word should hold after all accepted writes.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] w;
        w = ref_rd(a);
        if (be[0]) w[7:0]  = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        ref_mem[int'(a)] = w;
    endtask

    typedef struct { logic [15:0] data; int due; } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    logic last_acc = 1'b0;
    int n_rd_acc = 0, n_rsp = 0, spurious = 0;
    int viol_oe_we = 0, viol_drive = 0, viol_rdy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Protocol watch on the falling edge, where all registered pins are settled.
    always @(negedge clk) begin
        if (!sram_oe_n && !sram_we_n) viol_oe_we++;
        if (!sram_oe_n && dut.u_dq_buf.oe) viol_drive++;
        if (busy && req_ready) viol_rdy++;
    end

    // One clock: book accepted requests into the model, then score any response due now.
    task automatic step();
        logic acc;
        acc = req_valid && req_ready && reset;
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (!reset) begin
            n_rd_acc -= exp_q.size();
            exp_q.delete();
        end
        if (acc) begin
            if (req_we) ref_wr(req_addr, req_wdata, req_be);
            else begin
                exp_q.push_back('{data: ref_rd(req_addr), due: cyc + RD_WAIT + 1});
                n_rd_acc++;
            end
        end
        #1;
        if (rsp_valid) n_rsp++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid_due", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else if (rsp_valid) begin
            spurious++;
        end
    endtask

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                         input logic [1:0] be);
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        step();
        chk("accept", last_acc, 1);
        req_valid = 1'b0;
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt, prev, guard, waited;
        logic [ADDR_W-1:0] a;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;

        // Reset state
        repeat (3) step();
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_be_n", sram_be_n, 2'b11);
        chk("rst_dq_oe", dut.u_dq_buf.oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        step();
        chk("rst_ready", req_ready, 1);

        // Write 0xBEEF then read it back, checking the strobe sequence
        issue(1'b1, 18'h00010, 16'hBEEF, 2'b11);
        for (int k = 0; k <= WR_WAIT + 2; k++) begin
            if (k <= WR_WAIT) begin
                chk("wr_we_n", sram_we_n, 0);
                chk("wr_oe_n", sram_oe_n, 1);
                chk("wr_ce_n", sram_ce_n, 0);
                chk("wr_dq", sram_dq, 16'hBEEF);
            end else if (k == WR_WAIT + 1) begin
                chk("wrh_we_n", sram_we_n, 1);
                chk("wrh_ce_n", sram_ce_n, 0);
                chk("wrh_dq_oe", dut.u_dq_buf.oe, 1);
            end else begin
                chk("wr_end_ready", req_ready, 1);
                chk("wr_end_ce_n", sram_ce_n, 1);
                chk("wr_end_dq_oe", dut.u_dq_buf.oe, 0);
            end
            if (k < WR_WAIT + 2) step();
        end
        issue(1'b0, 18'h00010, 16'h0000, 2'b00);
        chk("rd_oe_n", sram_oe_n, 0);
        chk("rd_be_n", sram_be_n, 2'b00);
        chk("rd_addr", sram_addr, 18'h00010);
        chk("rd_ready", req_ready, 0);
        chk("rdata_ur", rdata_ur, 16'hBEEF);
        repeat (RD_WAIT + 1) step();
        chk("rd_beef", rsp_rdata, 16'hBEEF);
        step();
        chk("rsp_pulse_end", rsp_valid, 0);

        // Byte lanes: upper lane only, then an all-disabled write
        issue(1'b1, 18'h00020, 16'h1234, 2'b11);
        repeat (WR_WAIT + 3) step();
        issue(1'b1, 18'h00020, 16'hAB00, 2'b10);
        chk("lane_be_n", sram_be_n, 2'b01);
        repeat (WR_WAIT + 3) step();
        issue(1'b1, 18'h00020, 16'hFFFF, 2'b00);
        chk("be0_be_n", sram_be_n, 2'b11);
        chk("be0_we_n", sram_we_n, 0);
        repeat (WR_WAIT + 3) step();
        issue(1'b0, 18'h00020, 16'h0000, 2'b11);
        repeat (RD_WAIT + 2) step();
        chk("lane_read", rsp_rdata, 16'hAB34);

        // Top address
        issue(1'b1, 18'h3FFFF, 16'h5AA5, 2'b11);
        chk("max_addr", sram_addr, 18'h3FFFF);
        repeat (WR_WAIT + 3) step();
        issue(1'b0, 18'h3FFFF, 16'h0000, 2'b00);
        repeat (RD_WAIT + 2) step();
        chk("max_read", rsp_rdata, 16'h5AA5);

        // Back-to-back reads with valid held high
        req_we = 1'b0; req_addr = 18'h00010; req_valid = 1'b1;
        acc_cnt = 0; prev = -1; guard = 0;
        while (acc_cnt < 4 && guard < 40) begin
            step();
            guard++;
            if (last_acc) begin
                if (prev >= 0) chk("b2b_period", 32'(cyc - prev), B2B_PERIOD);
                prev = cyc;
                acc_cnt++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc_cnt, 4);
        repeat (B2B_PERIOD + 1) step();

        // Reset during the last read cycle aborts the read
        issue(1'b0, 18'h00020, 16'h0000, 2'b00);
        step();
        chk("mid_rd_busy", busy, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_oe_n", sram_oe_n, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        step();
        chk("abort_no_rsp", rsp_valid, 0);

        // Random mix
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) step();
            a = ($urandom_range(0, 3) == 3) ? (18'h3FFE0 | 18'($urandom_range(0, 31)))
                                            : 18'($urandom_range(0, 31));
            req_we = 1'($urandom); req_addr = a;
            req_wdata = 16'($urandom); req_be = 2'($urandom);
            req_valid = 1'b1;
            waited = 0;
            do begin
                step();
                waited++;
            end while (!last_acc && waited < 30);
            chk("rand_accept", last_acc, 1);
            req_valid = 1'b0;
            req_addr  = 18'($urandom);
            req_wdata = 16'($urandom);
        end
        repeat (10) step();

        chk("queue_drained", exp_q.size(), 0);
        chk("spurious_rsp", spurious, 0);
        chk("rsp_count", n_rsp, n_rd_acc);
        chk("oe_we_overlap", viol_oe_we, 0);
        chk("dq_drive_on_read", viol_drive, 0);
        chk("ready_while_busy", viol_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
